cpu_mem_responder: RTL and testbench

- Memory-side responder for the stack CPU's word bus (address, read data, write data, write strobe), plus the LED output strobe.
- Loads program words from a byte-serial boot stream after reset, then releases the CPU.
- Serves CPU reads and writes.
- Captures LED writes into a register with an event counter.

---
 rtl/cpu_bus_pkg.sv | 16 +
 rtl/cpu_mem_responder_if.sv | 29 ++
 rtl/cpu_mem_responder_ram.sv | 23 ++
 rtl/cpu_mem_responder.sv | 140 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types for the stack CPU memory responder.
// Bus width, default address width and loader FSM states.
package cpu_bus_pkg;

  localparam int DW         = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    RUN
  } ld_state_e;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU word bus, LED strobe and boot byte stream bundle.
// master: CPU/boot source side; slave: memory responder side.
interface cpu_mem_responder_if;

  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_wr;
  logic [15:0] bus_rdata;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        led_wr;
  logic [7:0]  led_data;

  modport master (
    output bus_addr, bus_wdata, bus_wr,
    output ld_valid, ld_byte,
    output led_wr, led_data,
    input  bus_rdata, ld_ready
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wr,
    input  ld_valid, ld_byte,
    input  led_wr, led_data,
    output bus_rdata, ld_ready
  );

endinterface

// File: rtl/cpu_mem_responder_ram.sv
// DEPTH x DW word array: one synchronous write port, one async read.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module resp_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Boot loader, word memory and LED capture for the stack CPU.
// Ports: clk, rst_n, bus (slave), cpu_run, ld_err, leds, led_count.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_mem_responder_if.slave bus,
  output logic             cpu_run,
  output logic             ld_err,
  output logic [7:0]       leds,
  output logic [CNT_W-1:0] led_count
);

  localparam logic [16:0] DEPTH17 = 17'(2**ADDR_W);

  ld_state_e         state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              err_q, err_d;
  logic [7:0]        leds_q, leds_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              run;
  logic              xfer;
  logic              in_range;
  logic [15:0]       hdr;
  logic              over;
  logic              ld_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  assign run      = (state_q == RUN);
  assign xfer     = bus.ld_valid && !run;
  assign in_range = (bus.bus_addr >> ADDR_W) == 16'd0;
  assign hdr      = {hi_q, bus.ld_byte};
  assign over     = {1'b0, hdr} > DEPTH17;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    waddr_d = waddr_q;
    last_d  = last_q;
    err_d   = err_q;
    leds_d  = leds_q;
    cnt_d   = cnt_q;
    ld_we   = 1'b0;
    if (xfer) begin
      unique case (state_q)
        HDR_HI: begin
          hi_d    = bus.ld_byte;
          state_d = HDR_LO;
        end
        HDR_LO: begin
          waddr_d = '0;
          state_d = (hdr == 16'd0) ? RUN : DATA_HI;
          // last_q holds count-1 so it fits ADDR_W bits
          if (over) begin
            err_d  = 1'b1;
            last_d = '1;
          end else begin
            last_d = hdr[ADDR_W-1:0] - ADDR_W'(1);
          end
        end
        DATA_HI: begin
          hi_d    = bus.ld_byte;
          state_d = DATA_LO;
        end
        DATA_LO: begin
          ld_we = 1'b1;
          if (waddr_q == last_q) begin
            state_d = RUN;
          end else begin
            waddr_d = waddr_q + ADDR_W'(1);
            state_d = DATA_HI;
          end
        end
        default: ;
      endcase
    end
    if (run && bus.led_wr) begin
      leds_d = bus.led_data;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR_HI;
      hi_q    <= '0;
      waddr_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      leds_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      waddr_q <= waddr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      leds_q  <= leds_d;
      cnt_q   <= cnt_d;
    end
  end

  // loader owns the write port until RUN, the CPU after
  assign ram_we    = run ? (bus.bus_wr && in_range)
                         : ld_we;
  assign ram_waddr = run ? bus.bus_addr[ADDR_W-1:0]
                         : waddr_q;
  assign ram_wdata = run ? bus.bus_wdata : hdr;

  resp_ram #(
    .AW (ADDR_W),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (bus.bus_addr[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  assign bus.bus_rdata = (run && in_range) ? ram_rdata
                                           : '0;
  assign bus.ld_ready  = !run;
  assign cpu_run       = run;
  assign ld_err        = err_q;
  assign leds          = leds_q;
  assign led_count     = cnt_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: byte-count model plus literal checks.
// Two instances: ADDR_W=8 (model-checked) and ADDR_W=2 (clamp case).
module tb_cpu_mem_responder;
  import cpu_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_mem_responder_if b8 ();
  cpu_mem_responder_if b2 ();

  logic        run8, err8, run2, err2;
  logic [7:0]  leds8, leds2;
  logic [15:0] cnt8, cnt2;

  cpu_mem_responder #(.ADDR_W(8), .CNT_W(16)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave),
    .cpu_run(run8), .ld_err(err8),
    .leds(leds8), .led_count(cnt8)
  );

  cpu_mem_responder #(.ADDR_W(2), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave),
    .cpu_run(run2), .ld_err(err2),
    .leds(leds2), .led_count(cnt2)
  );

  int tests = 0;
  int fails = 0;

  localparam int D8 = 256;
  logic [15:0] m_mem [D8];
  bit          m_known [D8];
  int          m_bytes, m_n;
  bit          m_run, m_err;
  logic [7:0]  m_hi, m_leds;
  logic [15:0] m_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes = 0; m_n = 0; m_run = 0; m_err = 0;
    m_hi = 0; m_leds = 0; m_cnt = 0;
  endtask

  // Rules in stream terms: byte 0/1 form N, then byte pairs fill words.
  task automatic model_step();
    int b, idx, n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_run) begin
      if (b8.ld_valid) begin
        b = m_bytes;
        m_bytes++;
        if (b == 0) m_hi = b8.ld_byte;
        else if (b == 1) begin
          n = int'({m_hi, b8.ld_byte});
          if (n > D8) begin m_err = 1; n = D8; end
          m_n = n;
          if (n == 0) m_run = 1;
        end else if (b % 2 == 0) m_hi = b8.ld_byte;
        else begin
          idx = (b - 3) / 2;
          m_mem[idx] = {m_hi, b8.ld_byte};
          m_known[idx] = 1;
          if (idx == m_n - 1) m_run = 1;
        end
      end
    end else begin
      if (b8.bus_wr && int'(b8.bus_addr) < D8) begin
        m_mem[b8.bus_addr[7:0]] = b8.bus_wdata;
        m_known[b8.bus_addr[7:0]] = 1;
      end
      if (b8.led_wr) begin
        m_leds = b8.led_data;
        m_cnt++;
      end
    end
  endtask

  task automatic compare();
    int a;
    a = int'(b8.bus_addr);
    chk("ld_ready", 32'(b8.ld_ready), 32'(!m_run));
    chk("cpu_run", 32'(run8), 32'(m_run));
    chk("ld_err", 32'(err8), 32'(m_err));
    chk("leds", 32'(leds8), 32'(m_leds));
    chk("led_count", 32'(cnt8), 32'(m_cnt));
    if (!m_run || a >= D8)
      chk("rdata_zero", 32'(b8.bus_rdata), 32'h0);
    else if (m_known[a])
      chk("rdata", 32'(b8.bus_rdata), 32'(m_mem[a]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic send8(input logic [7:0] v);
    b8.ld_valid = 1'b1;
    b8.ld_byte  = v;
    tick();
  endtask

  task automatic send2(input logic [7:0] v);
    b2.ld_valid = 1'b1;
    b2.ld_byte  = v;
    tick();
  endtask

  task automatic rd8(input logic [15:0] a,
                     input logic [15:0] e,
                     input string nm);
    b8.bus_addr = a;
    #1;
    chk(nm, 32'(b8.bus_rdata), 32'(e));
  endtask

  task automatic rd2(input logic [15:0] a,
                     input logic [15:0] e,
                     input string nm);
    b2.bus_addr = a;
    #1;
    chk(nm, 32'(b2.bus_rdata), 32'(e));
  endtask

  initial begin
    logic [7:0] s1 [8];
    logic [7:0] s2 [10];
    s1 = '{8'h00, 8'h03, 8'h80, 8'h05,
           8'h80, 8'h07, 8'h00, 8'h20};
    s2 = '{8'h00, 8'h05, 8'h11, 8'h11, 8'h22,
           8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
    b8.bus_addr = 0; b8.bus_wdata = 0; b8.bus_wr = 0;
    b8.ld_valid = 0; b8.ld_byte = 0;
    b8.led_wr = 0; b8.led_data = 0;
    b2.bus_addr = 0; b2.bus_wdata = 0; b2.bus_wr = 0;
    b2.ld_valid = 0; b2.ld_byte = 0;
    b2.led_wr = 0; b2.led_data = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_ready", 32'(b8.ld_ready), 32'd1);
    chk("rst_run", 32'(run8), 32'd0);
    chk("rst_err", 32'(err8), 32'd0);
    chk("rst_leds", 32'(leds8), 32'd0);
    chk("rst_cnt", 32'(cnt8), 32'd0);
    rst_n = 1'b1;

    // partial load with an LED strobe, then async reset
    send8(8'h00);
    b8.led_wr = 1'b1; b8.led_data = 8'hAA;
    send8(8'h03);
    b8.led_wr = 1'b0;
    send8(8'h80); send8(8'h05); send8(8'h80);
    b8.ld_valid = 1'b0;
    chk("load_led_ign", 32'(leds8), 32'h0);
    chk("load_cnt_ign", 32'(cnt8), 32'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ready", 32'(b8.ld_ready), 32'd1);
    chk("arst_run", 32'(run8), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;

    // full stream, valid held high
    for (int i = 0; i < 8; i++) begin
      send8(s1[i]);
      if (i == 6) chk("run_early", 32'(run8), 32'd0);
    end
    chk("run_set", 32'(run8), 32'd1);
    chk("ready_drop", 32'(b8.ld_ready), 32'd0);
    send8(8'h55); send8(8'h66);
    b8.ld_valid = 1'b0;
    rd8(16'h0000, 16'h8005, "rd0");
    rd8(16'h0001, 16'h8007, "rd1");
    rd8(16'h0002, 16'h0020, "rd2");
    tick();

    // read during write, then out-of-range write
    b8.bus_addr = 16'h0002; b8.bus_wdata = 16'hBEEF;
    b8.bus_wr = 1'b1;
    #1 chk("rdw_old", 32'(b8.bus_rdata), 32'h0020);
    tick();
    b8.bus_wr = 1'b0;
    #1 chk("rdw_new", 32'(b8.bus_rdata), 32'hBEEF);
    b8.bus_addr = 16'h0100; b8.bus_wdata = 16'h1234;
    b8.bus_wr = 1'b1;
    tick();
    b8.bus_wr = 1'b0;
    #1 chk("oor_rd", 32'(b8.bus_rdata), 32'h0);
    rd8(16'h0000, 16'h8005, "oor_alias");
    tick();

    // LED strobes, last two back-to-back
    b8.led_wr = 1'b1; b8.led_data = 8'h01; tick();
    b8.led_wr = 1'b0; tick();
    b8.led_wr = 1'b1; b8.led_data = 8'h02; tick();
    b8.led_data = 8'h03; tick();
    b8.led_wr = 1'b0; tick();
    chk("leds_3", 32'(leds8), 32'h03);
    chk("cnt_3", 32'(cnt8), 32'd3);

    // zero-length program
    rst_n = 1'b0; model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    b8.bus_addr = 16'h0000;
    send8(8'h00);
    chk("n0_run_early", 32'(run8), 32'd0);
    send8(8'h00);
    chk("n0_run", 32'(run8), 32'd1);
    chk("n0_err", 32'(err8), 32'd0);
    chk("n0_ready", 32'(b8.ld_ready), 32'd0);
    send8(8'h77); send8(8'h88);
    b8.ld_valid = 1'b0;
    rd8(16'h0000, 16'h8005, "n0_mem_kept");
    tick();

    // ADDR_W=2 instance: header exceeds depth
    rst_n = 1'b0; model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send2(s2[i]);
      if (i == 1) chk("clamp_err", 32'(err2), 32'd1);
      if (i == 8) chk("clamp_early", 32'(run2), 32'd0);
    end
    chk("clamp_run", 32'(run2), 32'd1);
    chk("clamp_ready", 32'(b2.ld_ready), 32'd0);
    send2(8'h55); send2(8'h66);
    chk("clamp_ready2", 32'(b2.ld_ready), 32'd0);
    b2.ld_valid = 1'b0;
    rd2(16'h0004, 16'h0000, "clamp_oor");
    rd2(16'h0003, 16'h4444, "clamp_rd3");
    rd2(16'h0000, 16'h1111, "clamp_rd0");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
